regfile_mov_sequencer: RTL and testbench

- Initiator/writer side of the 8x16 register file port (data_in, writenum, write, readnum, data_out).
- Accepts one 16-bit MOV instruction per start handshake and sequences the regfile read/write cycles to execute it.
- Supports MOV Rn,#imm8 and MOV Rd,Rm{,shift}.
- Sits between instruction fetch and the regfile.
- The regfile shares clk and reads combinationally.

---
 rtl/regfile_mov_sequencer.sv | 137 +++++++++++++
 tb/tb_regfile_mov_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mov_sequencer.sv
// regfile_mov_sequencer: issues MOV instructions to an 8xDW regfile.
// One instruction per start handshake; imm and shifted-register forms.
module regfile_mov_sequencer #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          s,
  input  logic [15:0]   in,
  input  logic [DW-1:0] data_out,
  output logic [2:0]    readnum,
  output logic [2:0]    writenum,
  output logic          write,
  output logic [DW-1:0] data_in,
  output logic          w,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_READ_RM,
    S_WRITE_RD
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [15:0]   r_ir;
  logic [DW-1:0] r_tmp;
  logic          r_done;
  logic          r_err;

  logic          w_done_set;
  logic          w_err_set;
  logic [2:0]    w_opc;
  logic [1:0]    w_op;
  logic [2:0]    w_rn;
  logic [2:0]    w_rd;
  logic [1:0]    w_sh;
  logic [2:0]    w_rm;
  logic [DW-1:0] w_sext;
  logic [DW-1:0] w_shift;
  logic          w_is_imm;
  logic          w_is_reg;

  assign w_opc = r_ir[15:13];
  assign w_op  = r_ir[12:11];
  assign w_rn  = r_ir[10:8];
  assign w_rd  = r_ir[7:5];
  assign w_sh  = r_ir[4:3];
  assign w_rm  = r_ir[2:0];

  assign w_sext   = DW'(signed'(r_ir[7:0]));
  assign w_is_imm = (w_opc == 3'b110) && (w_op == 2'b10);
  assign w_is_reg = (w_opc == 3'b110) && (w_op == 2'b00);

  assign w    = (r_state == S_WAIT);
  assign done = r_done;
  assign err  = r_err;

  // Shifter applied to the Rm read before it lands in TMP.
  always_comb begin
    w_shift = data_out;
    unique case (w_sh)
      2'b01:   w_shift = {data_out[DW-2:0], 1'b0};
      2'b10:   w_shift = {1'b0, data_out[DW-1:1]};
      2'b11:   w_shift = {data_out[DW-1], data_out[DW-1:1]};
      default: w_shift = data_out;
    endcase
  end

  // Next state and Moore regfile controls.
  always_comb begin
    w_nxt      = r_state;
    w_done_set = 1'b0;
    w_err_set  = 1'b0;
    readnum    = 3'd0;
    writenum   = 3'd0;
    write      = 1'b0;
    data_in    = '0;
    unique case (r_state)
      S_WAIT: begin
        if (s) w_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (w_is_imm) begin
          w_nxt = S_WRITE_IMM;
        end else if (w_is_reg) begin
          w_nxt = S_READ_RM;
        end else begin
          w_nxt     = S_WAIT;
          w_err_set = 1'b1;
        end
      end
      S_WRITE_IMM: begin
        write      = 1'b1;
        writenum   = w_rn;
        data_in    = w_sext;
        w_nxt      = S_WAIT;
        w_done_set = 1'b1;
      end
      S_READ_RM: begin
        readnum = w_rm;
        w_nxt   = S_WRITE_RD;
      end
      S_WRITE_RD: begin
        write      = 1'b1;
        writenum   = w_rd;
        data_in    = r_tmp;
        w_nxt      = S_WAIT;
        w_done_set = 1'b1;
      end
      default: w_nxt = S_WAIT;
    endcase
  end

  // State, instruction, operand and status-pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_WAIT;
      r_ir    <= '0;
      r_tmp   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_done  <= w_done_set;
      r_err   <= w_err_set;
      if (r_state == S_WAIT && s) r_ir <= in;
      if (r_state == S_READ_RM) r_tmp <= w_shift;
    end
  end

endmodule

// File: tb/tb_regfile_mov_sequencer.sv
// tb_regfile_mov_sequencer: directed vectors against a regfile model.
// Cycle n means the cycle after edge n-1, with edge 0 accepting s.
module tb_regfile_mov_sequencer;

  localparam int DW = 16;

  logic          clk;
  logic          reset_n;
  logic          s;
  logic [15:0]   in;
  logic [DW-1:0] data_out;
  logic [2:0]    readnum;
  logic [2:0]    writenum;
  logic          write;
  logic [DW-1:0] data_in;
  logic          w;
  logic          done;
  logic          err;

  logic [DW-1:0] rf [8];
  logic          pl_en;
  logic [2:0]    pl_idx;
  logic [DW-1:0] pl_val;

  int n_chk;
  int n_err;

  regfile_mov_sequencer #(.DW(DW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .s        (s),
    .in       (in),
    .data_out (data_out),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .data_in  (data_in),
    .w        (w),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data_out = rf[readnum];

  always @(posedge clk) begin
    if (pl_en) rf[pl_idx] <= pl_val;
    else if (write) rf[writenum] <= data_in;
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic preload(logic [2:0] idx, logic [DW-1:0] val);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  // Leaves the bench at #1 after edge 0 (start of cycle 1).
  task automatic start(logic [15:0] ins);
    @(negedge clk);
    in = ins;
    s  = 1'b1;
    @(posedge clk);
    #1;
    s  = 1'b0;
    in = 16'h0;
  endtask

  task automatic run_reg(string tag, logic [15:0] ins,
                         logic [2:0] rd, logic [DW-1:0] exp);
    start(ins);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_wr"}, write, 1);
    chk({tag, "_wn"}, writenum, rd);
    chk({tag, "_di"}, data_in, exp);
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_rf"}, rf[rd], exp);
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    s       = 1'b0;
    in      = 16'h0;
    pl_en   = 1'b0;
    pl_idx  = 3'd0;
    pl_val  = '0;
    for (int i = 0; i < 8; i++) preload(3'(i), '0);
    #2;
    chk("rst_w", w, 1);
    chk("rst_write", write, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rn", readnum, 0);
    chk("rst_wn", writenum, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // MOV R2,#42
    start(16'hD22A);
    @(negedge clk);
    chk("imm_c1_wr", write, 0);
    chk("imm_c1_w", w, 0);
    @(negedge clk);
    chk("imm_c2_wr", write, 1);
    chk("imm_c2_wn", writenum, 2);
    chk("imm_c2_di", data_in, 42);
    chk("imm_c2_done", done, 0);
    @(negedge clk);
    chk("imm_c3_done", done, 1);
    chk("imm_c3_w", w, 1);
    chk("imm_c3_wr", write, 0);
    chk("imm_r2", rf[2], 42);

    // MOV R5,#-1
    start(16'hD5FF);
    @(negedge clk);
    @(negedge clk);
    chk("neg_di", data_in, 16'hFFFF);
    chk("neg_wn", writenum, 5);
    @(negedge clk);
    chk("neg_done", done, 1);
    chk("neg_r5", rf[5], 16'hFFFF);
    @(negedge clk);
    chk("neg_done_pulse", done, 0);

    // MOV R7,R2
    start(16'hC0E2);
    @(negedge clk);
    @(negedge clk);
    chk("mr_c2_rn", readnum, 2);
    chk("mr_c2_wr", write, 0);
    @(negedge clk);
    chk("mr_c3_wr", write, 1);
    chk("mr_c3_wn", writenum, 7);
    chk("mr_c3_di", data_in, 42);
    chk("mr_c3_done", done, 0);
    @(negedge clk);
    chk("mr_c4_done", done, 1);
    chk("mr_r7", rf[7], 42);

    // Shifts of R5=8001 into R1, then Rd=Rm on R5
    preload(3'd5, 16'h8001);
    run_reg("lsl", 16'hC02D, 3'd1, 16'h0002);
    run_reg("lsr", 16'hC035, 3'd1, 16'h4000);
    run_reg("asr", 16'hC03D, 3'd1, 16'hC000);
    run_reg("self", 16'hC0AD, 3'd5, 16'h0002);

    // Unsupported
    start(16'hA000);
    @(negedge clk);
    chk("bad_c1_wr", write, 0);
    chk("bad_c1_err", err, 0);
    @(negedge clk);
    chk("bad_c2_err", err, 1);
    chk("bad_c2_done", done, 0);
    chk("bad_c2_w", w, 1);
    chk("bad_c2_wr", write, 0);
    @(negedge clk);
    chk("bad_c3_err", err, 0);

    // MOV R3,R2 with ignored s in READ_RM, then reset in WRITE_RD
    start(16'hC062);
    @(negedge clk);
    @(negedge clk);
    chk("ab_c2_rn", readnum, 2);
    s  = 1'b1;
    in = 16'hD7AA;
    @(posedge clk);
    #1;
    s  = 1'b0;
    in = 16'h0;
    @(negedge clk);
    chk("ab_c3_wr", write, 1);
    chk("ab_c3_wn", writenum, 3);
    chk("ab_c3_di", data_in, 42);
    #1;
    reset_n = 1'b0;
    #1;
    chk("ab_rst_wr", write, 0);
    chk("ab_rst_w", w, 1);
    chk("ab_rst_wn", writenum, 0);
    @(posedge clk);
    #1;
    chk("ab_r3", rf[3], 0);
    chk("ab_r7", rf[7], 42);
    chk("ab_done", done, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ab_post_w", w, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
